// File: rtl/state_seq_pkg.sv
// Shared types, constants and the legal successor table for the state sequencer.
// The table covers the graph 0..10; codes 11..15 can only be reached by injection.
package state_seq_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_INIT = 4'd0;
  localparam state_t ST_TERM = 4'd10;

  function automatic state_t next_state(input state_t s, input logic [1:0] sel);
    state_t n;
    case (s)
      4'd0:    n = 4'd1;
      4'd1:    n = sel[0] ? 4'd4 : 4'd2;
      4'd2:    n = 4'd3;
      4'd3:    n = sel[0] ? 4'd5 : 4'd1;
      4'd4:    n = 4'd5;
      4'd5:    n = sel[0] ? 4'd6 : 4'd1;
      4'd6:    n = 4'd7;
      4'd7:    n = 4'd8;
      4'd8: begin
        case (sel)
          2'd0:    n = 4'd2;
          2'd1:    n = 4'd4;
          2'd2:    n = 4'd9;
          default: n = 4'd10;
        endcase
      end
      4'd9:    n = 4'd8;
      4'd10:   n = 4'd10;
      default: n = ST_INIT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Per-state dwell timer: latches the dwell on state entry and raises adv once
// the state has been held for (latched dwell + 1) enabled cycles.
module dwell_timer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic               adv
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] lat_q;

  assign adv = en && (cnt_q == lat_q);

  // The counter parks at the latched value when an advance produces no new state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      lat_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
      lat_q <= dwell;
    end else if (en && !adv) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/state_seq_gen.sv
// Stimulus sequencer walking the legal state graph with per-state dwell and a saturating change count.
// Define ILLEGAL_INJECT_EN to add inj_req/inj_state for forcing arbitrary states at advance points.
module state_seq_gen
  import state_seq_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int DWELL_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               restart,
  input  logic [1:0]         sel,
  input  logic [DWELL_W-1:0] dwell,
`ifdef ILLEGAL_INJECT_EN
  input  logic               inj_req,
  input  logic [STATE_W-1:0] inj_state,
`endif
  output logic [STATE_W-1:0] state,
  output logic               state_chg,
  output logic               done,
  output logic [CNT_W-1:0]   trans_cnt
);

  state_t           state_q;
  state_t           state_d;
  logic             state_chg_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic             adv;
  logic             chg;
  logic             load;

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = ST_INIT;
`ifdef ILLEGAL_INJECT_EN
    end else if (adv && inj_req) begin
      state_d = state_t'(inj_state);
`endif
    end else if (adv) begin
      state_d = next_state(state_q, sel);
    end
  end

  // A self-loop (terminal state, or restart while already in 0) is not a change.
  assign chg  = (state_d != state_q);
  assign load = restart || chg;

  dwell_timer #(
    .DWELL_W(DWELL_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .load (load),
    .dwell(dwell),
    .adv  (adv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      state_chg_q <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      state_chg_q <= chg;
      done_q      <= (state_d == ST_TERM);
      if (chg && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign state     = STATE_W'(state_q);
  assign state_chg = state_chg_q;
  assign done      = done_q;
  assign trans_cnt = cnt_q;

endmodule

// File: tb/tb_state_seq_gen.sv
// Directed bench for state_seq_gen: legal walk, dwell/branching, freeze, terminal hold,
// restart priority, async reset mid-dwell, and injection when ILLEGAL_INJECT_EN is defined.
module tb_state_seq_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic        restart;
  logic [1:0]  sel;
  logic [3:0]  dwell;
`ifdef ILLEGAL_INJECT_EN
  logic        inj_req;
  logic [3:0]  inj_state;
`endif
  logic [3:0]  state;
  logic        state_chg;
  logic        done;
  logic [15:0] trans_cnt;

  int total;
  int bad;

  state_seq_gen dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .restart  (restart),
    .sel      (sel),
    .dwell    (dwell),
`ifdef ILLEGAL_INJECT_EN
    .inj_req  (inj_req),
    .inj_state(inj_state),
`endif
    .state    (state),
    .state_chg(state_chg),
    .done     (done),
    .trans_cnt(trans_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string name, input logic [3:0] st, input logic chg,
                            input logic dn, input logic [15:0] cnt);
    total++;
    if (state !== st || state_chg !== chg || done !== dn || trans_cnt !== cnt) begin
      bad++;
      $display("FAIL %s: got state=%0d chg=%b done=%b cnt=%0d, want state=%0d chg=%b done=%b cnt=%0d",
               name, state, state_chg, done, trans_cnt, st, chg, dn, cnt);
    end else begin
      $display("ok   %s: state=%0d chg=%b done=%b cnt=%0d", name, state, state_chg, done, trans_cnt);
    end
  endtask

  task automatic test_reset();
    #2;
    expect_all("reset_values", 4'd0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    expect_all("reset_release", 4'd0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic test_legal_walk();
    logic [3:0] walk [0:5];
    walk = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3};
    en = 1'b1;
    dwell = 4'd0;
    sel = 2'd0;
    for (int k = 0; k < 6; k++) begin
      step();
      expect_all($sformatf("walk_%0d", k), walk[k], 1'b1, 1'b0, 16'(k + 1));
    end
  endtask

  task automatic test_dwell_branch();
    logic [3:0] path [0:6];
    path = '{4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd4};
    @(negedge clk);
    dwell = 4'd3;
    sel = 2'd1;
    rst = 1'b1;
    #1;
    expect_all("async_rst_midcycle", 4'd0, 1'b0, 1'b0, 16'd0);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      step();
      expect_all($sformatf("dwell_edge_%0d", k), path[(k - 1) / 4],
                 ((k - 1) % 4) == 0, 1'b0, 16'((k - 1) / 4 + 1));
    end
  endtask

  task automatic test_enable_freeze();
    repeat (4) step();
    expect_all("freeze_in5", 4'd5, 1'b1, 1'b0, 16'd8);
    repeat (4) step();
    expect_all("freeze_in6", 4'd6, 1'b1, 1'b0, 16'd9);
    repeat (2) step();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      expect_all($sformatf("frozen_%0d", k), 4'd6, 1'b0, 1'b0, 16'd9);
    end
    en = 1'b1;
    step();
    expect_all("thaw_hold", 4'd6, 1'b0, 1'b0, 16'd9);
    step();
    expect_all("thaw_adv7", 4'd7, 1'b1, 1'b0, 16'd10);
  endtask

  task automatic test_terminal_restart();
    sel = 2'd3;
    repeat (4) step();
    expect_all("term_in8", 4'd8, 1'b1, 1'b0, 16'd11);
    repeat (4) step();
    expect_all("term_in10", 4'd10, 1'b1, 1'b1, 16'd12);
    for (int k = 0; k < 20; k++) begin
      step();
      expect_all($sformatf("term_hold_%0d", k), 4'd10, 1'b0, 1'b1, 16'd12);
    end
    dwell = 4'd0;
    restart = 1'b1;
    step();
    restart = 1'b0;
    expect_all("term_restart", 4'd0, 1'b1, 1'b0, 16'd13);
  endtask

  task automatic test_restart_priority();
    sel = 2'd0;
    step();
    expect_all("prio_in1", 4'd1, 1'b1, 1'b0, 16'd14);
    step();
    expect_all("prio_in2", 4'd2, 1'b1, 1'b0, 16'd15);
    step();
    expect_all("prio_in3", 4'd3, 1'b1, 1'b0, 16'd16);
    restart = 1'b1;
    step();
    expect_all("prio_restart_wins", 4'd0, 1'b1, 1'b0, 16'd17);
    restart = 1'b0;
    en = 1'b0;
    step();
    expect_all("prio_single_pulse", 4'd0, 1'b0, 1'b0, 16'd17);
    restart = 1'b1;
    step();
    restart = 1'b0;
    expect_all("restart_at_0_no_pulse", 4'd0, 1'b0, 1'b0, 16'd17);
  endtask

`ifdef ILLEGAL_INJECT_EN
  task automatic test_inject();
    en = 1'b1;
    dwell = 4'd0;
    sel = 2'd0;
    step();
    expect_all("inj_in1", 4'd1, 1'b1, 1'b0, 16'd18);
    inj_req = 1'b1;
    inj_state = 4'd7;
    step();
    expect_all("inj_to7", 4'd7, 1'b1, 1'b0, 16'd19);
    inj_state = 4'd12;
    step();
    expect_all("inj_to12", 4'd12, 1'b1, 1'b0, 16'd20);
    inj_req = 1'b0;
    step();
    expect_all("inj_12_to0", 4'd0, 1'b1, 1'b0, 16'd21);
  endtask
`endif

  task automatic test_async_reset_mid_dwell();
    en = 1'b1;
    dwell = 4'd3;
    sel = 2'd0;
    step();
    expect_all("mid_in1", 4'd1, 1'b1, 1'b0, trans_cnt_before_mid());
    repeat (2) step();
    #3;
    rst = 1'b1;
    #1;
    expect_all("mid_async_rst", 4'd0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    step();
    expect_all("post_rst_in1", 4'd1, 1'b1, 1'b0, 16'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      expect_all($sformatf("post_rst_hold_%0d", k), 4'd1, 1'b0, 1'b0, 16'd1);
    end
    step();
    expect_all("post_rst_in2", 4'd2, 1'b1, 1'b0, 16'd2);
  endtask

  function automatic logic [15:0] trans_cnt_before_mid();
`ifdef ILLEGAL_INJECT_EN
    return 16'd22;
`else
    return 16'd18;
`endif
  endfunction

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    en = 1'b0;
    restart = 1'b0;
    sel = 2'd0;
    dwell = 4'd0;
`ifdef ILLEGAL_INJECT_EN
    inj_req = 1'b0;
    inj_state = 4'd0;
`endif
    test_reset();
    test_legal_walk();
    test_dwell_branch();
    test_enable_freeze();
    test_terminal_restart();
    test_restart_priority();
`ifdef ILLEGAL_INJECT_EN
    test_inject();
`endif
    test_async_reset_mid_dwell();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
